// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and grid centre, shared by the timing
// generator and the rendering logic.
package vga_timing_pkg;
    localparam int COORD_W     = 10;
    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 784;
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_ACT_START = 35;
    localparam int V_ACT_END   = 515;
    localparam int CENTER_X    = 463;
    localparam int CENTER_Y    = 275;

    typedef logic [COORD_W-1:0] coord_t;

    // Half-open window test [lo, hi), unsigned.
    function automatic logic in_span(coord_t c, coord_t lo, coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction
endpackage

// File: rtl/display_timing_gen_if.sv
// Raster timing bundle: run enable in, counters/syncs/strobes out.
interface display_timing_gen_if;
    import vga_timing_pkg::*;

    logic   en;
    coord_t hCount;
    coord_t vCount;
    logic   bright;
    logic   hSync;
    logic   vSync;
    logic   pix_en;
    logic   line_tick;
    logic   frame_tick;

    modport master (
        input  en,
        output hCount, vCount, bright, hSync, vSync, pix_en, line_tick, frame_tick
    );

    modport slave (
        output en,
        input  hCount, vCount, bright, hSync, vSync, pix_en, line_tick, frame_tick
    );
endinterface

// File: rtl/clk_en_div.sv
// Clock-enable divider: counts enabled clocks modulo CLK_DIV and emits a
// registered one-clock pulse after each terminal count.
module clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic adv,
    output logic pulse
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // adv is the same-cycle advance condition; pulse is its registered copy.
    assign adv = en && (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= adv;
            if (adv)
                div <= '0;
            else if (en)
                div <= div + 1'b1;
        end
    end
endmodule

// File: rtl/display_timing_gen.sv
// 640x480@60 raster timing: pixel/line counters with zero-skew registered
// bright/sync outputs and per-pixel, per-line and per-frame strobes.
module display_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_ACT_START = vga_timing_pkg::H_ACT_START,
    parameter int H_ACT_END   = vga_timing_pkg::H_ACT_END,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_ACT_START = vga_timing_pkg::V_ACT_START,
    parameter int V_ACT_END   = vga_timing_pkg::V_ACT_END
) (
    input logic                  clk,
    input logic                  rst,
    display_timing_gen_if.master vga
);
    import vga_timing_pkg::*;

    if (CLK_DIV < 1 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_param
        $error("display_timing_gen: CLK_DIV must be >= 1 and totals <= 1024");
    end

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t H_SW   = coord_t'(H_SYNC);
    localparam coord_t V_SW   = coord_t'(V_SYNC);
    localparam coord_t H_AS   = coord_t'(H_ACT_START);
    localparam coord_t H_AE   = coord_t'(H_ACT_END);
    localparam coord_t V_AS   = coord_t'(V_ACT_START);
    localparam coord_t V_AE   = coord_t'(V_ACT_END);

    logic   adv;
    logic   h_wrap, v_wrap;
    coord_t h_cnt, v_cnt;
    coord_t h_nxt, v_nxt;
    logic   bright_r, hsync_r, vsync_r, line_r, frame_r;

    clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst   (rst),
        .en    (vga.en),
        .adv   (adv),
        .pulse (vga.pix_en)
    );

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_nxt  = h_cnt;
        v_nxt  = v_cnt;
        if (adv) begin
            h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap)
                v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
        end
    end

    // Decode from the next counter values so outputs land on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            bright_r <= 1'b0;
            hsync_r  <= 1'b0;
            vsync_r  <= 1'b0;
            line_r   <= 1'b0;
            frame_r  <= 1'b0;
        end else begin
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            bright_r <= in_span(h_nxt, H_AS, H_AE) && in_span(v_nxt, V_AS, V_AE);
            hsync_r  <= !(h_nxt < H_SW);
            vsync_r  <= !(v_nxt < V_SW);
            line_r   <= adv && h_wrap;
            frame_r  <= adv && h_wrap && v_wrap;
        end
    end

    assign vga.hCount     = h_cnt;
    assign vga.vCount     = v_cnt;
    assign vga.bright     = bright_r;
    assign vga.hSync      = hsync_r;
    assign vga.vSync      = vsync_r;
    assign vga.line_tick  = line_r;
    assign vga.frame_tick = frame_r;
endmodule
